bullet_slot_arbiter: RTL and testbench
======================================

// Module: bullet_slot_arbiter
// PURPOSE
//  Owns the shared pool of on-screen bullet slots and decides once per frame which shooter may fire.
//  Shooters are the player and the enemy columns; the bullet motion datapath reports when a slot is freed.
//  Sits between the player/enemy_array fire requests and the bullet datapath, gated by gameFSM is_playing.
//  Enforces one player bullet in flight, one reserved player slot, enemy round-robin and an enemy cooldown.
// PARAMETERS
//  NUM_SLOTS       4   bullet slots in the pool (>=2); slot index width SW = $clog2(NUM_SLOTS)
//  ENEMY_COLS      8   enemy columns that can request fire; column index width CW = $clog2(ENEMY_COLS)
//  ENEMY_COOLDOWN  30  frames between successive enemy launches (0 = launch every frame)
// PORTS
//  Clk             in   1           system clock; single clock domain
//  Reset           in   1           synchronous, active-high reset
//  is_playing      in   1           from gameFSM; low = pool held empty
//  frame_tick      in   1           one-cycle pulse per video frame, Clk domain
//  player_fire     in   1           pulse; player fire button edge
//  enemy_fire_req  in   ENEMY_COLS  level; bit c = column c has a live shooter wanting to fire
//  slot_release    in   NUM_SLOTS   pulse; bit i = bullet in slot i hit something or left the screen
//  slot_busy       out  NUM_SLOTS   bit i = slot i holds a live bullet
//  slot_owner      out  NUM_SLOTS   bit i: 0 = player, 1 = enemy; valid only where slot_busy=1
//  player_active   out  1           some busy slot is player-owned
//  launch_valid    out  1           one-cycle pulse: bullet launched this cycle
//  launch_slot     out  SW          slot launched; valid with launch_valid
//  launch_owner    out  1           0 = player, 1 = enemy; valid with launch_valid
//  launch_col      out  CW          enemy column granted; 0 for player launches
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; player_pend=0; cooldown=0; rr_ptr=0.
//  All outputs are registered.
//  States and transitions:
//   IDLE    -> WAIT when is_playing=1.
//   WAIT    -> P_ALLOC on frame_tick.
//   P_ALLOC -> E_ALLOC unconditionally.
//   E_ALLOC -> WAIT unconditionally.
//   Any state -> IDLE when is_playing=0. This overrides everything.
//  Leaving play: on the next edge clear slot_busy, slot_owner, player_pend, cooldown and rr_ptr, and hold launch_valid low.
//  frame_tick is ignored outside WAIT.
//  player_pend:
//   Set on player_fire when player_active=0 and is_playing=1.
//   player_fire is ignored while a player bullet is in flight or already pending.
//   Cleared when the player is launched.
//  P_ALLOC, entered at cycle N+1 after a tick in cycle N:
//   Fires if player_pend=1 and any slot is free; take the lowest-index free slot.
//   In cycle N+2: launch_valid=1, launch_owner=0, launch_col=0.
//   In cycle N+2: slot_busy bit set, owner bit 0, player_active=1.
//   No free slot: player_pend stays set and is retried on the next frame.
//  E_ALLOC, in cycle N+2; sees busy bits including any N+2 player launch:
//   Fires only if all of the following hold:
//    - cooldown=0;
//    - at least one enemy_fire_req bit is set;
//    - number of enemy-owned busy slots < NUM_SLOTS-1 (one slot always reserved for the player);
//    - a free slot exists.
//   Column choice: the first requesting column scanning upward from rr_ptr, wrapping at ENEMY_COLS-1 -> 0.
//   Slot choice: lowest-index free slot.
//   In cycle N+3: launch_valid=1, launch_owner=1, launch_col=column.
//   On launch: rr_ptr <= (column+1) mod ENEMY_COLS; cooldown <= ENEMY_COOLDOWN.
//  Cooldown: decrements by 1 on each frame_tick seen in WAIT, saturating at 0. The load in E_ALLOC wins over the decrement.
//  Launch rate: at most two launches per frame, player first then enemy, never in the same cycle.
//  slot_release[i]:
//   Clears busy bit i at the next edge.
//   Release of a non-busy slot: no effect.
//   Allocation uses the registered busy bits, so a slot released in cycle k can be granted from cycle k+1 onward.
//   Multiple release bits in one cycle are all honoured.
//  Release of a player slot: player_active drops the next cycle; a new player_fire is accepted from that cycle.
//  Reset asserted mid-allocation: pending launch is dropped; outputs are 0 at the next edge.
// TESTING
//  1. Reset, is_playing=1, player_fire, frame_tick@N -> launch_valid@N+2, slot=0, owner=0; player_active=1; slot_busy=0001.
//  2. Player active, second player_fire, 3 ticks -> no player launch; slot_release=0001 -> player_active=0 next cycle; next fire launches slot 0.
//  3. enemy_fire_req=8'h81, COOLDOWN=0, 2 ticks -> launches on col 0 then col 7; rr_ptr wraps to 0; slots 0 then 1.
//  4. NUM_SLOTS=4, all enemy req, COOLDOWN=0 -> exactly 3 enemy slots fill; 4th withheld; player_fire then launches slot 3.
//  5. COOLDOWN=30 -> enemy launches exactly 31 ticks apart; is_playing=0 mid-run -> slot_busy=0, cooldown=0 next cycle.
//  6. slot_release on a free slot plus a release in the same cycle as frame_tick -> no corruption; freed slot granted in P_ALLOC.

Source files
------------

// File: rtl/bullet_slot_arbiter.sv
// Bullet slot pool arbiter: grants at most one player and one
// enemy launch per frame from a shared pool of bullet slots.
module bullet_slot_arbiter #(
  parameter int NUM_SLOTS      = 4,
  parameter int ENEMY_COLS     = 8,
  parameter int ENEMY_COOLDOWN = 30,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int CW = (ENEMY_COLS > 1) ? $clog2(ENEMY_COLS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  is_playing,
  input  logic                  frame_tick,
  input  logic                  player_fire,
  input  logic [ENEMY_COLS-1:0] enemy_fire_req,
  input  logic [NUM_SLOTS-1:0]  slot_release,
  output logic [NUM_SLOTS-1:0]  slot_busy,
  output logic [NUM_SLOTS-1:0]  slot_owner,
  output logic                  player_active,
  output logic                  launch_valid,
  output logic [SW-1:0]         launch_slot,
  output logic                  launch_owner,
  output logic [CW-1:0]         launch_col
);

  localparam int DW = $clog2(ENEMY_COOLDOWN + 2);
  localparam int NW = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE, WAIT, P_ALLOC, E_ALLOC
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]        cool, cool_n;
  logic                 cool_ok, cool_ok_n;
  logic [CW-1:0]        rr, rr_n;
  logic                 pend, pend_n;
  logic [NUM_SLOTS-1:0] busy_n, owner_n;
  logic                 pa_n, lv_n, lo_n;
  logic [SW-1:0]        ls_n;
  logic [CW-1:0]        lc_n;

  logic [SW-1:0]        free_idx;
  logic                 has_free;
  logic [NW-1:0]        ecnt;
  logic [CW-1:0]        col, cidx;
  logic                 col_found;
  logic                 p_go, e_go;
  int                   c;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!is_playing) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = WAIT;
        WAIT:    if (frame_tick) state_n = P_ALLOC;
        P_ALLOC: state_n = E_ALLOC;
        E_ALLOC: state_n = WAIT;
      endcase
    end
  end

  always_comb begin
    free_idx  = '0;
    has_free  = |(~slot_busy);
    ecnt      = '0;
    col       = '0;
    cidx      = '0;
    col_found = 1'b0;
    c         = 0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!slot_busy[i]) free_idx = SW'(i);
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_busy[i] && slot_owner[i]) ecnt = ecnt + NW'(1);
    for (int k = 0; k < ENEMY_COLS; k++) begin
      c    = (int'(rr) + k) % ENEMY_COLS;
      cidx = CW'(c);
      if (!col_found && enemy_fire_req[cidx]) begin
        col_found = 1'b1;
        col       = cidx;
      end
    end

    p_go = (state == P_ALLOC) && pend && has_free;
    e_go = (state == E_ALLOC) && cool_ok && col_found
           && (ecnt < NW'(NUM_SLOTS - 1)) && has_free;

    busy_n  = slot_busy & ~slot_release;
    owner_n = slot_owner & ~slot_release;
    if (p_go || e_go) begin
      busy_n[free_idx]  = 1'b1;
      owner_n[free_idx] = e_go;
    end
    pa_n = |(busy_n & ~owner_n);
    lv_n = p_go || e_go;
    ls_n = lv_n ? free_idx : '0;
    lo_n = e_go;
    lc_n = e_go ? col : '0;

    pend_n = p_go ? 1'b0 : (pend | (player_fire & ~player_active));

    // gate on the count seen at this frame's tick: a load of C
    // leaves C launch-free frames before the next enemy shot
    cool_n    = cool;
    cool_ok_n = cool_ok;
    if (state == WAIT && frame_tick) begin
      cool_ok_n = (cool == '0);
      if (cool != '0) cool_n = cool - DW'(1);
    end
    rr_n = rr;
    if (e_go) begin
      cool_n = DW'(ENEMY_COOLDOWN);
      rr_n   = (col == CW'(ENEMY_COLS - 1)) ? '0 : col + CW'(1);
    end

    if (!is_playing) begin
      busy_n    = '0;
      owner_n   = '0;
      pa_n      = 1'b0;
      lv_n      = 1'b0;
      ls_n      = '0;
      lo_n      = 1'b0;
      lc_n      = '0;
      pend_n    = 1'b0;
      cool_n    = '0;
      cool_ok_n = 1'b0;
      rr_n      = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot_busy     <= '0;
      slot_owner    <= '0;
      player_active <= 1'b0;
      launch_valid  <= 1'b0;
      launch_slot   <= '0;
      launch_owner  <= 1'b0;
      launch_col    <= '0;
      pend          <= 1'b0;
      cool          <= '0;
      cool_ok       <= 1'b0;
      rr            <= '0;
    end else begin
      slot_busy     <= busy_n;
      slot_owner    <= owner_n;
      player_active <= pa_n;
      launch_valid  <= lv_n;
      launch_slot   <= ls_n;
      launch_owner  <= lo_n;
      launch_col    <= lc_n;
      pend          <= pend_n;
      cool          <= cool_n;
      cool_ok       <= cool_ok_n;
      rr            <= rr_n;
    end
  end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Directed bench for bullet_slot_arbiter: cycle table on a
// zero-cooldown instance plus cooldown / reset sequences.
module tb_bullet_slot_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       is_playing = 1'b0;
  logic       frame_tick = 1'b0;
  logic       player_fire = 1'b0;
  logic [7:0] enemy_fire_req = '0;
  logic [3:0] slot_release = '0;

  logic [3:0] busy0, own0, busy30, own30;
  logic       pa0, lv0, lo0, pa30, lv30, lo30;
  logic [1:0] ls0, ls30;
  logic [2:0] lc0, lc30;

  int compared = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  bullet_slot_arbiter #(.ENEMY_COOLDOWN(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .is_playing(is_playing),
    .frame_tick(frame_tick), .player_fire(player_fire),
    .enemy_fire_req(enemy_fire_req),
    .slot_release(slot_release),
    .slot_busy(busy0), .slot_owner(own0),
    .player_active(pa0), .launch_valid(lv0),
    .launch_slot(ls0), .launch_owner(lo0),
    .launch_col(lc0)
  );

  bullet_slot_arbiter dut30 (
    .Clk(Clk), .Reset(Reset), .is_playing(is_playing),
    .frame_tick(frame_tick), .player_fire(player_fire),
    .enemy_fire_req(enemy_fire_req),
    .slot_release(slot_release),
    .slot_busy(busy30), .slot_owner(own30),
    .player_active(pa30), .launch_valid(lv30),
    .launch_slot(ls30), .launch_owner(lo30),
    .launch_col(lc30)
  );

  typedef struct packed {
    logic       play, tick, fire;
    logic [7:0] req;
    logic [3:0] rel;
    logic [3:0] busy, own;
    logic       pa, lv;
    logic [1:0] slot;
    logic       lo;
    logic [2:0] col;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic pl, tk, fi,
    input logic [7:0] rq, input logic [3:0] rl,
    input logic [3:0] bs, ow, input logic p, v,
    input logic [1:0] s, input logic o, input logic [2:0] cl);
    vec_t r;
    r.play = pl; r.tick = tk; r.fire = fi;
    r.req = rq; r.rel = rl; r.busy = bs; r.own = ow;
    r.pa = p; r.lv = v; r.slot = s; r.lo = o; r.col = cl;
    return r;
  endfunction

  function automatic logic [15:0] pack(
    input logic [3:0] bs, ow, input logic p, v,
    input logic [1:0] s, input logic o, input logic [2:0] cl);
    return {bs, ow & bs, p, v, v ? s : 2'd0,
            v ? o : 1'b0, v ? cl : 3'd0};
  endfunction

  function automatic logic [15:0] obs0();
    return pack(busy0, own0, pa0, lv0, ls0, lo0, lc0);
  endfunction

  function automatic logic [15:0] obs30();
    return pack(busy30, own30, pa30, lv30, ls30, lo30, lc30);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic frame(input bit rel_after,
                       output logic l0, output logic l30);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    l0  = lv0 & lo0;
    l30 = lv30 & lo30;
    if (rel_after) begin
      slot_release = 4'hF;
      step();
      slot_release = 4'h0;
    end
  endtask

  initial begin
    logic l0, l30;
    vec_t v;

    // row: play tick fire req rel | busy own pa lv slot lo col
    tbl[0]  = mk(1,0,1,8'h00,4'h0, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[1]  = mk(1,1,0,8'h00,4'h0, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[2]  = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,1,2'd0,0,3'd0);
    tbl[3]  = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[4]  = mk(1,0,1,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[5]  = mk(1,1,0,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[6]  = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[7]  = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[8]  = mk(1,1,1,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[9]  = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[10] = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[11] = mk(1,0,0,8'h00,4'h1, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[12] = mk(1,0,1,8'h00,4'h0, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[13] = mk(1,1,0,8'h00,4'h0, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[14] = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,1,2'd0,0,3'd0);
    tbl[15] = mk(1,0,0,8'h00,4'h0, 4'h1,4'h0,1,0,2'd0,0,3'd0);
    tbl[16] = mk(1,0,0,8'h00,4'h1, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[17] = mk(1,1,0,8'h81,4'h0, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[18] = mk(1,0,0,8'h81,4'h0, 4'h0,4'h0,0,0,2'd0,0,3'd0);
    tbl[19] = mk(1,0,0,8'h81,4'h0, 4'h1,4'h1,0,1,2'd0,1,3'd0);
    tbl[20] = mk(1,1,0,8'h81,4'h0, 4'h1,4'h1,0,0,2'd0,0,3'd0);
    tbl[21] = mk(1,0,0,8'h81,4'h0, 4'h1,4'h1,0,0,2'd0,0,3'd0);
    tbl[22] = mk(1,0,0,8'h81,4'h0, 4'h3,4'h3,0,1,2'd1,1,3'd7);
    tbl[23] = mk(1,1,0,8'h81,4'h0, 4'h3,4'h3,0,0,2'd0,0,3'd0);
    tbl[24] = mk(1,0,0,8'h81,4'h0, 4'h3,4'h3,0,0,2'd0,0,3'd0);
    tbl[25] = mk(1,0,0,8'h81,4'h0, 4'h7,4'h7,0,1,2'd2,1,3'd0);
    tbl[26] = mk(1,1,0,8'hFF,4'h0, 4'h7,4'h7,0,0,2'd0,0,3'd0);
    tbl[27] = mk(1,0,0,8'hFF,4'h0, 4'h7,4'h7,0,0,2'd0,0,3'd0);
    tbl[28] = mk(1,0,0,8'hFF,4'h0, 4'h7,4'h7,0,0,2'd0,0,3'd0);
    tbl[29] = mk(1,0,1,8'h00,4'h0, 4'h7,4'h7,0,0,2'd0,0,3'd0);
    tbl[30] = mk(1,1,0,8'h00,4'h0, 4'h7,4'h7,0,0,2'd0,0,3'd0);
    tbl[31] = mk(1,0,0,8'h00,4'h0, 4'hF,4'h7,1,1,2'd3,0,3'd0);
    tbl[32] = mk(1,0,0,8'h00,4'h0, 4'hF,4'h7,1,0,2'd0,0,3'd0);
    tbl[33] = mk(1,0,0,8'h00,4'h8, 4'h7,4'h7,0,0,2'd0,0,3'd0);
    tbl[34] = mk(1,0,1,8'h00,4'h0, 4'h7,4'h7,0,0,2'd0,0,3'd0);
    tbl[35] = mk(1,1,0,8'h00,4'h9, 4'h6,4'h6,0,0,2'd0,0,3'd0);
    tbl[36] = mk(1,0,0,8'h00,4'h0, 4'h7,4'h6,1,1,2'd0,0,3'd0);
    tbl[37] = mk(1,0,0,8'h00,4'h0, 4'h7,4'h6,1,0,2'd0,0,3'd0);

    Reset = 1'b1;
    step();
    step();
    chk("reset_dut0", 32'(obs0()), 32'h0);
    chk("reset_dut30", 32'(obs30()), 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      is_playing     = v.play;
      frame_tick     = v.tick;
      player_fire    = v.fire;
      enemy_fire_req = v.req;
      slot_release   = v.rel;
      step();
      chk($sformatf("row%0d", i), 32'(obs0()),
          32'(pack(v.busy, v.own, v.pa, v.lv,
                   v.slot, v.lo, v.col)));
    end
    frame_tick = 1'b0;
    player_fire = 1'b0;
    slot_release = 4'h0;

    // cooldown spacing: one enemy shot, then 30 idle frames
    is_playing = 1'b0;
    enemy_fire_req = 8'h00;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    is_playing = 1'b1;
    enemy_fire_req = 8'h01;
    step();
    for (int k = 0; k < 63; k++) begin
      frame(1'b1, l0, l30);
      chk($sformatf("cd30_frame%0d", k), 32'(l30),
          32'((k % 31) == 0));
      chk($sformatf("cd0_frame%0d", k), 32'(l0), 32'h1);
    end

    frame(1'b0, l0, l30);
    chk("cd30_after_reload", 32'(l30), 32'h0);
    chk("busy_before_stop", 32'(busy0), 32'h1);
    is_playing = 1'b0;
    step();
    chk("stop_clears_dut0", 32'(obs0()), 32'h0);
    chk("stop_clears_dut30", 32'(obs30()), 32'h0);
    is_playing = 1'b1;
    step();
    frame(1'b1, l0, l30);
    chk("cooldown_cleared", 32'(l30), 32'h1);

    // reset while a player launch is in progress
    enemy_fire_req = 8'h00;
    player_fire = 1'b1;
    step();
    player_fire = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    Reset = 1'b1;
    step();
    chk("midalloc_reset", 32'(obs0()), 32'h0);
    Reset = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("pend_dropped", 32'(obs0()), 32'h0);
    step();
    chk("pend_dropped_e", 32'(obs0()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
